// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline: registers the decoded
// control bundle and operands for EX, detects load-use hazards and honours flushes.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_shamt,
  input  logic [15:0]       id_imm16,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [3:0]        Ctrl_alu,
  input  logic              Ctrl_regDst,
  input  logic [1:0]        Ctrl_aluSrcA,
  input  logic [1:0]        Ctrl_aluSrcB,
  input  logic              Ctrl_Mem2Reg,
  input  logic              Ctrl_ext,
  input  logic              Ctrl_regWr,
  input  logic              Ctrl_MemWr,
  input  logic [1:0]        Ctrl_branch,
  input  logic              Ctrl_jump,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_shamt,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_wa,
  output logic [3:0]        ex_alu,
  output logic [1:0]        ex_aluSrcA,
  output logic [1:0]        ex_aluSrcB,
  output logic              ex_Mem2Reg,
  output logic              ex_regWr,
  output logic              ex_MemWr,
  output logic [1:0]        ex_branch,
  output logic              ex_jump,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [DATA_W-1:0] imm_ext;
  logic [4:0]        wa;
  logic              uses_rs;
  logic              uses_rt;
  logic              hazard;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    imm_ext = {{(DATA_W-16){1'b0}}, id_imm16};
    if (Ctrl_ext) imm_ext = {{(DATA_W-16){id_imm16[15]}}, id_imm16};
    wa      = Ctrl_regDst ? id_rd : id_rt;
    uses_rs = (Ctrl_aluSrcA == 2'b00) && !Ctrl_jump;
    uses_rt = ((Ctrl_aluSrcB == 2'b00) || Ctrl_MemWr || (Ctrl_aluSrcA == 2'b10)) && !Ctrl_jump;
    // A load still in EX whose target a valid ID instruction reads; $0 never stalls.
    hazard  = id_valid && ex_valid && ex_Mem2Reg && ex_regWr && (ex_wa != 5'd0) &&
              ((uses_rs && (ex_wa == id_rs)) || (uses_rt && (ex_wa == id_rt)));
  end

  // The ID instruction is discarded on a flush, so there is nothing to hold.
  assign stall = hazard && !flush;

  // NOTE: pipeline state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc4     <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_shamt   <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_wa      <= '0;
      ex_alu     <= '0;
      ex_aluSrcA <= '0;
      ex_aluSrcB <= '0;
      ex_Mem2Reg <= 1'b0;
      ex_regWr   <= 1'b0;
      ex_MemWr   <= 1'b0;
      ex_branch  <= '0;
      ex_jump    <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      // Data fields are don't-care in a bubble, so they load unconditionally.
      ex_pc4     <= id_pc4;
      ex_a       <= id_rdata1;
      ex_b       <= id_rdata2;
      ex_imm     <= imm_ext;
      ex_shamt   <= id_shamt;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_wa      <= wa;
      ex_alu     <= Ctrl_alu;
      ex_aluSrcA <= Ctrl_aluSrcA;
      ex_aluSrcB <= Ctrl_aluSrcB;
      if (flush || hazard) begin
        ex_valid   <= 1'b0;
        ex_Mem2Reg <= 1'b0;
        ex_regWr   <= 1'b0;
        ex_MemWr   <= 1'b0;
        ex_branch  <= '0;
        ex_jump    <= 1'b0;
        if (!flush && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else begin
        ex_valid   <= id_valid;
        ex_Mem2Reg <= Ctrl_Mem2Reg;
        ex_regWr   <= Ctrl_regWr  && id_valid;
        ex_MemWr   <= Ctrl_MemWr  && id_valid;
        ex_branch  <= id_valid ? Ctrl_branch : 2'b00;
        ex_jump    <= Ctrl_jump   && id_valid;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised scoreboard bench for id_ex_stage: a reference model predicts the
// EX register contents and stall; monitors pop expectations and compare.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct {
    logic          rst, valid, flush;
    logic [DW-1:0] pc4, rd1, rd2;
    logic [4:0]    rs, rt, rd, shamt;
    logic [15:0]   imm;
    logic [3:0]    alu;
    logic          regdst, m2r, ext, regwr, memwr, jump;
    logic [1:0]    srca, srcb, branch;
  } in_t;

  typedef struct {
    logic          full;   // data fields meaningful (not a bubble)
    logic          valid, m2r, regwr, memwr, jump;
    logic [DW-1:0] pc4, a, b, imm;
    logic [4:0]    shamt, rs, rt, wa;
    logic [3:0]    alu;
    logic [1:0]    srca, srcb, branch;
    logic [CW-1:0] cnt;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, id_valid, flush, stall, ex_valid;
  logic [DW-1:0]     id_pc4, id_rdata1, id_rdata2, ex_pc4, ex_a, ex_b, ex_imm;
  logic [4:0]        id_rs, id_rt, id_rd, id_shamt, ex_shamt, ex_rs, ex_rt, ex_wa;
  logic [15:0]       id_imm16;
  logic [3:0]        Ctrl_alu, ex_alu;
  logic              Ctrl_regDst, Ctrl_Mem2Reg, Ctrl_ext, Ctrl_regWr, Ctrl_MemWr, Ctrl_jump;
  logic [1:0]        Ctrl_aluSrcA, Ctrl_aluSrcB, Ctrl_branch;
  logic [1:0]        ex_aluSrcA, ex_aluSrcB, ex_branch;
  logic              ex_Mem2Reg, ex_regWr, ex_MemWr, ex_jump;
  logic [CW-1:0]     bubble_cnt;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc4(id_pc4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_imm16(id_imm16),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .Ctrl_alu(Ctrl_alu), .Ctrl_regDst(Ctrl_regDst), .Ctrl_aluSrcA(Ctrl_aluSrcA),
    .Ctrl_aluSrcB(Ctrl_aluSrcB), .Ctrl_Mem2Reg(Ctrl_Mem2Reg), .Ctrl_ext(Ctrl_ext),
    .Ctrl_regWr(Ctrl_regWr), .Ctrl_MemWr(Ctrl_MemWr), .Ctrl_branch(Ctrl_branch),
    .Ctrl_jump(Ctrl_jump), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wa(ex_wa), .ex_alu(ex_alu),
    .ex_aluSrcA(ex_aluSrcA), .ex_aluSrcB(ex_aluSrcB), .ex_Mem2Reg(ex_Mem2Reg),
    .ex_regWr(ex_regWr), .ex_MemWr(ex_MemWr), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .bubble_cnt(bubble_cnt)
  );

  int   total = 0;
  int   bad   = 0;
  rec_t exp_q[$];
  logic stall_q[$];
  rec_t m;                 // model of the current EX register contents
  logic known = 1'b0;      // model valid once the first reset edge has happened
  logic last_stall = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t rnd_in();
    in_t x;
    x.rst = 1'b0; x.flush = 1'b0; x.valid = 1'b1;
    x.pc4 = $urandom; x.rd1 = $urandom; x.rd2 = $urandom;
    x.rs = 5'($urandom_range(0, 3)); x.rt = 5'($urandom_range(0, 3));
    x.rd = 5'($urandom_range(0, 3)); x.shamt = 5'($urandom);
    x.imm = 16'($urandom); x.alu = 4'($urandom);
    x.regdst = 1'($urandom); x.m2r = 1'($urandom); x.ext = 1'($urandom);
    x.regwr = 1'($urandom); x.memwr = 1'($urandom); x.jump = ($urandom_range(0, 7) == 0);
    x.srca = 2'($urandom); x.srcb = 2'($urandom); x.branch = 2'($urandom);
    return x;
  endfunction

  function automatic in_t lw(input logic [4:0] dst);
    in_t x = rnd_in();
    x.rs = 5'd1; x.rt = dst; x.regdst = 1'b0; x.srca = 2'b00; x.srcb = 2'b01;
    x.m2r = 1'b1; x.regwr = 1'b1; x.memwr = 1'b0; x.jump = 1'b0; x.branch = 2'b00; x.ext = 1'b1;
    return x;
  endfunction

  function automatic in_t rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    in_t x = rnd_in();
    x.rs = s; x.rt = t; x.rd = d; x.regdst = 1'b1; x.srca = 2'b00; x.srcb = 2'b00;
    x.m2r = 1'b0; x.regwr = 1'b1; x.memwr = 1'b0; x.jump = 1'b0; x.branch = 2'b00;
    return x;
  endfunction

  // Drive one cycle of ID inputs, predict stall and the next EX contents.
  task automatic step(input in_t x);
    rec_t n;
    logic urs, urt, hz;
    @(negedge clk);
    rst = x.rst; id_valid = x.valid; flush = x.flush; id_pc4 = x.pc4;
    id_rs = x.rs; id_rt = x.rt; id_rd = x.rd; id_shamt = x.shamt; id_imm16 = x.imm;
    id_rdata1 = x.rd1; id_rdata2 = x.rd2; Ctrl_alu = x.alu; Ctrl_regDst = x.regdst;
    Ctrl_aluSrcA = x.srca; Ctrl_aluSrcB = x.srcb; Ctrl_Mem2Reg = x.m2r; Ctrl_ext = x.ext;
    Ctrl_regWr = x.regwr; Ctrl_MemWr = x.memwr; Ctrl_branch = x.branch; Ctrl_jump = x.jump;
    #1;
    urs = (x.srca == 2'b00) && !x.jump;
    urt = (x.srcb == 2'b00 || x.memwr || x.srca == 2'b10) && !x.jump;
    hz  = known && x.valid && m.valid && m.m2r && m.regwr && (m.wa != 0) &&
          ((urs && m.wa == x.rs) || (urt && m.wa == x.rt));
    last_stall = hz && !x.flush;
    if (known) stall_q.push_back(last_stall);
    n = m;
    if (x.rst) begin
      n = '{full: 1'b1, default: '0};
    end else if (x.flush || hz) begin
      n.full = 1'b0; n.valid = 1'b0; n.m2r = 1'b0; n.regwr = 1'b0;
      n.memwr = 1'b0; n.branch = 2'b00; n.jump = 1'b0;
      if (!x.flush && m.cnt < CW'((1 << CW) - 1)) n.cnt = m.cnt + 1;
    end else begin
      n.full = 1'b1; n.valid = x.valid; n.pc4 = x.pc4; n.a = x.rd1; n.b = x.rd2;
      n.imm = x.ext ? DW'($signed(x.imm)) : DW'(x.imm);
      n.shamt = x.shamt; n.rs = x.rs; n.rt = x.rt; n.wa = x.regdst ? x.rd : x.rt;
      n.alu = x.alu; n.srca = x.srca; n.srcb = x.srcb; n.m2r = x.m2r;
      n.regwr = x.valid && x.regwr; n.memwr = x.valid && x.memwr;
      n.branch = x.valid ? x.branch : 2'b00; n.jump = x.valid && x.jump;
    end
    if (known || x.rst) begin
      exp_q.push_back(n);
      m = n;
      known = 1'b1;
    end
  endtask

  // Stall monitor: stall is combinational, sampled mid-cycle after inputs settle.
  initial forever begin
    @(negedge clk); #2;
    if (stall_q.size() != 0) check("stall", DW'(stall), DW'(stall_q.pop_front()));
  end

  // EX monitor: compare registered outputs just after each rising edge.
  initial forever begin
    rec_t e;
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ex_valid", DW'(ex_valid), DW'(e.valid));
      check("ex_regWr", DW'(ex_regWr), DW'(e.regwr));
      check("ex_MemWr", DW'(ex_MemWr), DW'(e.memwr));
      check("ex_branch", DW'(ex_branch), DW'(e.branch));
      check("ex_jump", DW'(ex_jump), DW'(e.jump));
      check("ex_Mem2Reg", DW'(ex_Mem2Reg), DW'(e.m2r));
      check("bubble_cnt", DW'(bubble_cnt), DW'(e.cnt));
      if (e.full) begin
        check("ex_pc4", ex_pc4, e.pc4);
        check("ex_a", ex_a, e.a);
        check("ex_b", ex_b, e.b);
        check("ex_imm", ex_imm, e.imm);
        check("ex_shamt", DW'(ex_shamt), DW'(e.shamt));
        check("ex_rs", DW'(ex_rs), DW'(e.rs));
        check("ex_rt", DW'(ex_rt), DW'(e.rt));
        check("ex_wa", DW'(ex_wa), DW'(e.wa));
        check("ex_alu", DW'(ex_alu), DW'(e.alu));
        check("ex_aluSrcA", DW'(ex_aluSrcA), DW'(e.srca));
        check("ex_aluSrcB", DW'(ex_aluSrcB), DW'(e.srcb));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    in_t x, cur;
    // Reset held two cycles with a live instruction presented.
    repeat (2) begin x = rnd_in(); x.rst = 1'b1; step(x); end
    // ADDI $2,$1,-1 (sign-extended) and ORI with zero extension.
    x = rnd_in(); x.rs = 1; x.rt = 2; x.imm = 16'hFFFF; x.ext = 1; x.regdst = 0;
    x.srca = 2'b00; x.srcb = 2'b01; x.regwr = 1; x.m2r = 0; x.memwr = 0; x.jump = 0; step(x);
    x.imm = 16'h8000; x.ext = 0; step(x);
    // Load-use: LW $3 then ADD $4,$3,$5 held across the stall.
    step(lw(3)); x = rtype(3, 5, 4); step(x); step(x);
    // No false stall: load to $0, and a consumer writing (not reading) $3.
    step(lw(0)); step(rtype(0, 0, 6));
    step(lw(3)); x = rtype(0, 3, 7); x.regdst = 0; x.srcb = 2'b01; step(x);
    // Flush coinciding with a load-use hazard.
    step(lw(3)); x = rtype(3, 5, 4); x.flush = 1; step(x);
    // Reset in the middle of a stall.
    step(lw(2)); x = rtype(2, 1, 4); step(x); x.rst = 1; step(x);
    // Randomised traffic; IF/ID holds its instruction while stalled.
    cur = rnd_in();
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        cur = rnd_in();
        if ($urandom_range(0, 2) == 0) cur = lw(5'($urandom_range(0, 3)));
        cur.valid = ($urandom_range(0, 7) != 0);
      end
      cur.flush = ($urandom_range(0, 9) == 0);
      cur.rst   = ($urandom_range(0, 49) == 0);
      step(cur);
    end
    // Saturation: 17 load-use bubbles on a 4-bit counter.
    x = rnd_in(); x.rst = 1; step(x);
    for (int i = 0; i < 17; i++) begin
      step(lw(3)); x = rtype(3, 3, 1); step(x); step(x);
    end
    step(rtype(0, 0, 0));
    @(posedge clk); #3;
    check("bubble_cnt_saturated", DW'(bubble_cnt), DW'(4'hF));
    repeat (2) @(negedge clk);
    #3;
    check("queues_drained", DW'(exp_q.size() + stall_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage MIPS pipeline, directly downstream of the instruction decoder (control unit).
- Each cycle it registers the decoder's control bundle, register-file read data, the extended immediate, shamt and the resolved destination register for the EX stage.
- It also detects load-use hazards, stalling IF/ID and inserting a bubble.
- It accepts a flush from the branch/jump resolver.

Parameters:
- DATA_W, 32, datapath width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- id_rs, id_rt, id_rd  in  5 each  instruction register fields
- id_shamt  in  5  shift amount
- id_imm16  in  16  immediate
- id_rdata1, id_rdata2  in  DATA_W  register-file read data
- Ctrl_alu  in  4  decoder control input
- Ctrl_regDst  in  1  decoder control input
- Ctrl_aluSrcA  in  2  decoder control input
- Ctrl_aluSrcB  in  2  decoder control input
- Ctrl_Mem2Reg  in  1  decoder control input
- Ctrl_ext  in  1  decoder control input
- Ctrl_regWr  in  1  decoder control input
- Ctrl_MemWr  in  1  decoder control input
- Ctrl_branch  in  2  decoder control input
- Ctrl_jump  in  1  decoder control input
- flush  in  1  branch taken / jump from later stage; kill ID contents
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_pc4  out  DATA_W  registered id_pc4
- ex_a, ex_b  out  DATA_W  registered rdata1 / rdata2
- ex_imm  out  DATA_W  extended immediate
- ex_shamt  out  5  registered shamt
- ex_rs, ex_rt  out  5  registered source fields, for forwarding
- ex_wa  out  5  resolved write register
- ex_alu  out  4  registered control
- ex_aluSrcA  out  2  registered control
- ex_aluSrcB  out  2  registered control
- ex_Mem2Reg  out  1  registered control
- ex_regWr  out  1  registered control
- ex_MemWr  out  1  registered control
- ex_branch  out  2  registered control
- ex_jump  out  1  registered control
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset: all registered outputs are 0; ex_valid=0; bubble_cnt=0.
- Reset state is a NOP bubble: regWr=0, MemWr=0, branch=00, jump=0.

Combinational helpers:
- Immediate: ext=1 sign-extends imm16 to DATA_W; ext=0 zero-extends. Computed combinationally, registered into ex_imm.
- Write register: wa = Ctrl_regDst ? id_rd : id_rt.
- uses_rs = (Ctrl_aluSrcA==2'b00) && !Ctrl_jump.
- uses_rt = (Ctrl_aluSrcB==2'b00 || Ctrl_MemWr || Ctrl_aluSrcA==2'b10) && !Ctrl_jump.

Hazard detection:
- hazard = id_valid & ex_valid & ex_Mem2Reg & ex_regWr & (ex_wa!=0) & ((uses_rs & ex_wa==id_rs) | (uses_rt & ex_wa==id_rt)).
- stall = hazard & !flush. A flush overrides the stall: the ID instruction is discarded anyway.

Per rising edge, priority order:
1. rst: load the reset values.
2. flush: load a bubble (ex_valid=0; regWr, MemWr, branch, jump, Mem2Reg cleared; data fields don't-care). bubble_cnt unchanged.
3. hazard: load a bubble; bubble_cnt += 1, saturating at all ones.
4. Otherwise: load all ID fields; ex_valid=id_valid.
   - If id_valid=0, regWr, MemWr, branch and jump are also forced to 0, so control never leaks from an invalid slot.

Timing and boundary rules:
- Latency is exactly 1 cycle; there is no backpressure from EX.
- A load-use hazard causes exactly one stall cycle. Next cycle ex_valid=0, so hazard drops and the held instruction enters.
- If ex_wa=0, no stall is raised (writes to $0 are ignored).
- flush and hazard in the same cycle: bubble loaded, stall=0, counter not incremented.
- Reset asserted mid-stall: next cycle everything is cleared and stall=0.
- Unknown opcode (control inputs held stale by the decoder): registered as given; legality is the decoder's responsibility.

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1 and arbitrary inputs -> all ex_* = 0, ex_valid=0, bubble_cnt=0, stall=0.
- Pass-through: ADDI rs=1 rt=2 imm=16'hFFFF, ext=1 -> next cycle ex_imm=32'hFFFFFFFF, ex_wa=2, ex_regWr=1, ex_aluSrcB=01.
- Pass-through: ORI imm=16'h8000, ext=0 -> ex_imm=32'h00008000.
- Load-use: LW $3 in EX, then ADD $4,$3,$5 in ID -> stall=1 for one cycle, ex_valid=0 next cycle, bubble_cnt=1; ADD enters the cycle after, with stall=0.
- No false stall: LW $0 in EX followed by a consumer of $0 -> stall=0. LW $3 followed by ADDI with rt=3 (rt is the destination only) -> stall=0.
- Flush priority: flush=1 in the same cycle as a load-use hazard -> stall=0, ex_valid=0, ex_regWr=0, bubble_cnt unchanged.
- Counter saturation: with CNT_W=4, force 17 hazards -> bubble_cnt stays at 4'hF.
